// File: rtl/ir_encoder.sv
// ir_encoder
//   Pulse-distance IR transmitter. A 32-bit code is sent MSB first as a sync
//   burst and sync silence, then one burst plus one silence per bit, where
//   the silence length encodes the bit. A final burst closes the frame, and
//   a mandatory idle-high gap follows before the next frame can start.
//
// Ports
//   clk_in      system clock, rising edge
//   rst_in      asynchronous active-low reset
//   code_in     code to transmit, captured on acceptance
//   valid_in    send request, accepted only while ready_out is high
//   abort_in    cancel the frame in progress (no-op in IDLE and GAP_WAIT)
//   ready_out   high only in IDLE
//   signal_out  IR line: 0 = burst, 1 = silence/idle
//   done_out    one-cycle pulse on return to IDLE after a completed frame
//   state_out   current FSM state code
module ir_encoder #(
  parameter int SBD  = 900,
  parameter int SSD  = 450,
  parameter int BBD  = 60,
  parameter int BSD0 = 60,
  parameter int BSD1 = 160,
  parameter int GAP  = 50
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        valid_in,
  input  logic        abort_in,
  output logic        ready_out,
  output logic        signal_out,
  output logic        done_out,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_SYNC_BURST   = 3'd1,
    ST_SYNC_SILENCE = 3'd2,
    ST_BIT_BURST    = 3'd3,
    ST_BIT_SILENCE  = 3'd4,
    ST_FINAL_BURST  = 3'd5,
    ST_GAP_WAIT     = 3'd6,
    ST_UNUSED       = 3'd7
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_DUR = max2(max2(max2(SBD, SSD), max2(BBD, BSD0)), max2(BSD1, GAP));
  localparam int CNT_W   = $clog2(MAX_DUR) + 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       bit_q, bit_d;
  logic [31:0]      code_q, code_d;
  logic             aborted_q, aborted_d;
  logic             signal_q, signal_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] last_cnt;
  logic             at_last;

  // Counter value on the final cycle of the current state. The IDLE cycle
  // that carries done_out is the last cycle of the mandatory gap, so
  // GAP_WAIT itself occupies GAP-1 cycles and frames accepted in the done
  // cycle are separated by exactly GAP idle-high cycles.
  always_comb begin
    // NOTE: every combinational output is given a default before the case so
    // that no path through the block leaves it unassigned and infers a latch.
    last_cnt = '0;
    case (state_q)
      ST_SYNC_BURST:   last_cnt = CNT_W'(SBD - 1);
      ST_SYNC_SILENCE: last_cnt = CNT_W'(SSD - 1);
      ST_BIT_BURST:    last_cnt = CNT_W'(BBD - 1);
      ST_BIT_SILENCE:  last_cnt = code_q[bit_q[4:0]] ? CNT_W'(BSD1 - 1) : CNT_W'(BSD0 - 1);
      ST_FINAL_BURST:  last_cnt = CNT_W'(BBD - 1);
      ST_GAP_WAIT:     last_cnt = CNT_W'(GAP - 2);
      default:         last_cnt = '0;
    endcase
  end

  assign at_last = (cnt_q == last_cnt);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_d     = bit_q;
    code_d    = code_q;
    aborted_d = aborted_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (valid_in) begin
          state_d   = ST_SYNC_BURST;
          code_d    = code_in;
          bit_d     = 6'd31;
          aborted_d = 1'b0;
        end
      end
      ST_SYNC_BURST: if (at_last) begin
        state_d = ST_SYNC_SILENCE;
        cnt_d   = '0;
      end
      ST_SYNC_SILENCE: if (at_last) begin
        state_d = ST_BIT_BURST;
        cnt_d   = '0;
      end
      ST_BIT_BURST: if (at_last) begin
        state_d = ST_BIT_SILENCE;
        cnt_d   = '0;
      end
      ST_BIT_SILENCE: if (at_last) begin
        cnt_d = '0;
        if (bit_q == 6'd0) begin
          state_d = ST_FINAL_BURST;
        end else begin
          state_d = ST_BIT_BURST;
          bit_d   = bit_q - 6'd1;
        end
      end
      ST_FINAL_BURST: if (at_last) begin
        state_d = ST_GAP_WAIT;
        cnt_d   = '0;
      end
      ST_GAP_WAIT: if (at_last) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = !aborted_q;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort overrides normal sequencing in any transmitting state; the gap
    // is still honoured, but the frame is not reported as done.
    if (abort_in && (state_q inside {ST_SYNC_BURST, ST_SYNC_SILENCE, ST_BIT_BURST,
                                     ST_BIT_SILENCE, ST_FINAL_BURST})) begin
      state_d   = ST_GAP_WAIT;
      cnt_d     = '0;
      aborted_d = 1'b1;
      done_d    = 1'b0;
    end

    // Outputs are registered from the next state so they line up with state_out.
    ready_d  = (state_d == ST_IDLE);
    signal_d = !(state_d inside {ST_SYNC_BURST, ST_BIT_BURST, ST_FINAL_BURST});
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      code_q    <= '0;
      aborted_q <= 1'b0;
      signal_q  <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      code_q    <= code_d;
      aborted_q <= aborted_d;
      signal_q  <= signal_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign ready_out  = ready_q;
  assign signal_out = signal_q;
  assign done_out   = done_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_ir_encoder.sv
// tb_ir_encoder
//   Self-checking bench for ir_encoder at default timing. Frames are checked
//   against a reference built from the line-coding rules: a list of expected
//   low/high run lengths per code, plus the closed-form frame length.
module tb_ir_encoder;

  localparam int SBD  = 900;
  localparam int SSD  = 450;
  localparam int BBD  = 60;
  localparam int BSD0 = 60;
  localparam int BSD1 = 160;
  localparam int GAP  = 50;
  localparam int FRAME_LIMIT = 20000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] code_in = '0;
  logic        valid_in = 1'b0;
  logic        abort_in = 1'b0;
  logic        ready_out;
  logic        signal_out;
  logic        done_out;
  logic [2:0]  state_out;

  int n_checks = 0;
  int n_fail   = 0;

  ir_encoder #(
    .SBD(SBD), .SSD(SSD), .BBD(BBD), .BSD0(BSD0), .BSD1(BSD1), .GAP(GAP)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .code_in   (code_in),
    .valid_in  (valid_in),
    .abort_in  (abort_in),
    .ready_out (ready_out),
    .signal_out(signal_out),
    .done_out  (done_out),
    .state_out (state_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Expected frame length up to the start of the gap, from the coding rules.
  function automatic int frame_len(input logic [31:0] code);
    int n1 = $countones(code);
    return SBD + SSD + BBD + 32 * BBD + n1 * BSD1 + (32 - n1) * BSD0;
  endfunction

  // Wait for ready_out, then present code_in for exactly one accepting edge.
  task automatic start_frame(input logic [31:0] code);
    int n = 0;
    @(negedge clk_in);
    while (!ready_out && n < FRAME_LIMIT) begin
      @(negedge clk_in);
      n++;
    end
    check("start_ready", ready_out, 1'b1);
    code_in  = code;
    valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    code_in  = $urandom;
  endtask

  // Called just after the accepting edge. Records run lengths of signal_out
  // up to and including the done_out cycle and compares with the reference.
  task automatic capture_frame(input string tag, input logic [31:0] code,
                               output int total, output logic [31:0] decoded);
    int   exp_runs[$];
    int   runs[$];
    int   cur_len;
    logic cur_lvl;
    bit   seen_done;
    int   cycles;

    exp_runs.push_back(SBD);
    exp_runs.push_back(SSD);
    for (int b = 31; b >= 0; b--) begin
      exp_runs.push_back(BBD);
      exp_runs.push_back(code[b] ? BSD1 : BSD0);
    end
    exp_runs.push_back(BBD);
    exp_runs.push_back(GAP);

    @(negedge clk_in);
    check($sformatf("%s_first_low", tag), signal_out, 1'b0);
    check($sformatf("%s_busy", tag), ready_out, 1'b0);
    cur_lvl   = signal_out;
    cur_len   = 1;
    cycles    = 1;
    seen_done = 1'b0;
    while (!seen_done && cycles < FRAME_LIMIT) begin
      @(negedge clk_in);
      cycles++;
      if (signal_out == cur_lvl) begin
        cur_len++;
      end else begin
        runs.push_back(cur_len);
        cur_lvl = signal_out;
        cur_len = 1;
      end
      if (done_out) begin
        seen_done = 1'b1;
        check($sformatf("%s_done_ready", tag), ready_out, 1'b1);
        check($sformatf("%s_done_state", tag), state_out, 3'd0);
        check($sformatf("%s_done_line", tag), signal_out, 1'b1);
      end
    end
    runs.push_back(cur_len);
    check($sformatf("%s_done_seen", tag), seen_done, 1'b1);

    total   = 0;
    decoded = '0;
    check($sformatf("%s_run_count", tag), runs.size(), exp_runs.size());
    if (runs.size() == exp_runs.size()) begin
      for (int i = 0; i < runs.size(); i++)
        check($sformatf("%s_run%0d", tag, i), runs[i], exp_runs[i]);
      for (int i = 0; i < runs.size() - 1; i++) total += runs[i];
      for (int b = 0; b < 32; b++)
        decoded[31 - b] = (runs[3 + 2 * b] > (BSD0 + BSD1) / 2);
      check($sformatf("%s_len", tag), total, frame_len(code));
      check($sformatf("%s_decode", tag), decoded, code);
    end
  endtask

  initial begin
    int          total;
    logic [31:0] dec;
    logic [31:0] code;
    int          off;
    int          k;
    int          dones;
    int          lows;

    // Reset values, asserted and just after release.
    #12;
    check("rst_signal", signal_out, 1'b1);
    check("rst_ready", ready_out, 1'b1);
    check("rst_done", done_out, 1'b0);
    check("rst_state", state_out, 3'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("idle_signal", signal_out, 1'b1);
    check("idle_state", state_out, 3'd0);

    // Reference frame with known bit pattern and length.
    start_frame(32'hABCD_1234);
    capture_frame("abcd", 32'hABCD_1234, total, dec);
    check("abcd_len_6750", total, 6750);

    // Code that the companion decoder should recover.
    start_frame(32'h1986_1989);
    capture_frame("dec", 32'h1986_1989, total, dec);
    check("dec_code", dec, 32'h1986_1989);

    // Random codes.
    for (int r = 0; r < 2; r++) begin
      code = $urandom;
      start_frame(code);
      capture_frame($sformatf("rnd%0d", r), code, total, dec);
    end

    // Back-to-back: valid held high, second frame accepted in the done cycle,
    // so the second capture begins right after the first one's gap.
    @(negedge clk_in);
    code_in  = 32'hFFFF_FFFF;
    valid_in = 1'b1;
    @(posedge clk_in);
    #1;
    code_in = 32'h0000_0000;
    capture_frame("b2b_a", 32'hFFFF_FFFF, total, dec);
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    capture_frame("b2b_b", 32'h0000_0000, total, dec);
    check("b2b_b_len", total, SBD + SSD + BBD + 32 * (BBD + BSD0));

    // Abort during bit 5's burst.
    code = $urandom;
    start_frame(code);
    off = SBD + SSD;
    for (int b = 31; b >= 6; b--) off += BBD + (code[b] ? BSD1 : BSD0);
    off += 10;
    repeat (off + 1) @(negedge clk_in);
    check("abort_pre_burst", signal_out, 1'b0);
    check("abort_pre_state", state_out, 3'd3);
    abort_in = 1'b1;
    @(posedge clk_in);
    #1;
    abort_in = 1'b0;
    k = 0;
    dones = 0;
    @(negedge clk_in);
    k++;
    check("abort_line_high", signal_out, 1'b1);
    check("abort_state_gap", state_out, 3'd6);
    while (!ready_out && k < FRAME_LIMIT) begin
      @(negedge clk_in);
      k++;
      if (done_out) dones++;
    end
    check("abort_ready_delay", k, GAP);
    repeat (3) @(negedge clk_in) if (done_out) dones++;
    check("abort_no_done", dones, 0);

    // Asynchronous reset in the middle of the sync silence.
    start_frame($urandom);
    repeat (SBD + 100) @(negedge clk_in);
    check("mid_sync_silence", state_out, 3'd2);
    #3;
    rst_in = 1'b0;
    #1;
    check("arst_signal", signal_out, 1'b1);
    check("arst_state", state_out, 3'd0);
    check("arst_ready", ready_out, 1'b1);
    code     = $urandom;
    code_in  = code;
    valid_in = 1'b1;
    @(negedge clk_in);
    check("arst_hold_state", state_out, 3'd0);
    #2;
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    valid_in = 1'b0;
    capture_frame("post_rst", code, total, dec);

    // valid_in pulsed with another code during a bit silence is ignored.
    code = $urandom;
    start_frame(code);
    fork
      capture_frame("ign", code, total, dec);
      begin
        repeat (SBD + SSD + BBD + 6) @(negedge clk_in);
        code_in  = ~code;
        valid_in = 1'b1;
        @(negedge clk_in);
        valid_in = 1'b0;
      end
    join
    lows = 0;
    repeat (200) @(negedge clk_in) if (!signal_out) lows++;
    check("ign_no_second", lows, 0);
    check("ign_idle", state_out, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
